// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // Sequencer states for one memory access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // RV32I funct3 encodings for loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: legality/alignment check, store lane
// steering with byte strobes, and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_read,
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic        bad,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic       legal;
  logic       aligned;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  // Reject read+write together, unknown funct3 and misaligned addresses.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    legal   = 1'b0;
    aligned = 1'b0;
    if (is_read && !is_write) begin
      legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end else if (is_write && !is_read) begin
      legal = funct3 inside {F3_B, F3_H, F3_W};
    end
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offset[0];
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b0;
    endcase
    bad = ~(legal & aligned);
  end

  // Replicate store data into every lane and enable only the addressed bytes.
  always_comb begin
    wdata = '0;
    wstrb = '0;
    if (is_write) begin
      case (funct3)
        F3_B: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << offset;
        end
        F3_H: begin
          wdata = {2{store_data[15:0]}};
          wstrb = offset[1] ? 4'b1100 : 4'b0011;
        end
        F3_W: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    case (ld_offset)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      F3_W:    ld_data = rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: runs one req/ready bus transaction per
// accepted access, stalls the core meanwhile and pulses done on completion.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            access_fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT   = CW'(TIMEOUT_CYCLES);

  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    ld_f3_q;
  logic [1:0]    ld_off_q;

  logic          access;
  logic          req_bad;
  logic [31:0]   wdata_c;
  logic [3:0]    wstrb_c;
  logic [31:0]   ld_data_c;
  logic          start, reject, complete, fault;

  assign access = valid & (mem_read | mem_write);
  assign stall  = ((state_q == IDLE) && access) || (state_q == BUSY);

  lsu_align u_align (
    .is_read    (mem_read),
    .is_write   (mem_write),
    .funct3     (funct3),
    .offset     (alu_out[1:0]),
    .store_data (store_data),
    .bad        (req_bad),
    .wdata      (wdata_c),
    .wstrb      (wstrb_c),
    .ld_funct3  (ld_f3_q),
    .ld_offset  (ld_off_q),
    .rdata      (bus_rdata),
    .ld_data    (ld_data_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and one-cycle strobes for the datapath.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    reject   = 1'b0;
    complete = 1'b0;
    fault    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (req_bad) begin
            reject  = 1'b1;
            state_d = DONE;
          end else begin
            start   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A ready in the final allowed cycle still completes normally.
        if (bus_ready) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (cnt_q >= LIMIT) begin
          fault   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating timeout counter, cleared on entry to BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (state_q == BUSY && !bus_ready && cnt_q != SAT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bus outputs and latched request fields; held stable through BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_write;
      bus_addr  <= {alu_out[31:2], 2'b00};
      bus_wdata <= wdata_c;
      bus_wstrb <= wstrb_c;
      ld_f3_q   <= funct3;
      ld_off_q  <= alu_out[1:0];
    end else if (complete || fault) begin
      bus_req   <= 1'b0;
    end
  end

  // Completion pulse, status flags and extended load result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done         <= 1'b0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      load_data    <= '0;
    end else begin
      done         <= reject | complete | fault;
      misaligned   <= reject;
      access_fault <= fault;
      if (complete && !bus_we) load_data <= ld_data_c;
      else                     load_data <= '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] store_data = '0;
  logic        stall, done, misaligned, access_fault;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    valid      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_out    = addr;
    store_data = sd;
  endtask

  task automatic idle_in();
    valid     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Load with bus_ready on the first BUSY cycle.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word_addr, input logic [31:0] rd,
                          input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, addr, 32'h0);
    #1;
    check({tag, "_stall_req"}, stall, 1);
    tick();
    idle_in();
    check({tag, "_busreq"}, bus_req, 1);
    check({tag, "_addr"}, bus_addr, word_addr);
    check({tag, "_we"}, bus_we, 0);
    check({tag, "_wstrb"}, bus_wstrb, 0);
    check({tag, "_stall_busy"}, stall, 1);
    bus_ready = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_data"}, load_data, exp);
    check({tag, "_stall_done"}, stall, 0);
    check({tag, "_req_drop"}, bus_req, 0);
    tick();
    check({tag, "_done_clr"}, done, 0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] word_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    issue(1'b0, 1'b1, f3, addr, sd);
    tick();
    idle_in();
    check({tag, "_busreq"}, bus_req, 1);
    check({tag, "_we"}, bus_we, 1);
    check({tag, "_addr"}, bus_addr, word_addr);
    check({tag, "_wdata"}, bus_wdata, exp_wdata);
    check({tag, "_wstrb"}, bus_wstrb, exp_wstrb);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_data0"}, load_data, 0);
    check({tag, "_fault"}, misaligned | access_fault, 0);
    tick();
  endtask

  // Rejected access: done + misaligned one cycle after valid, no bus traffic.
  task automatic run_bad(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr);
    issue(rd, wr, f3, addr, 32'hFFFF_FFFF);
    #1;
    check({tag, "_stall_req"}, stall, 1);
    tick();
    idle_in();
    check({tag, "_done"}, done, 1);
    check({tag, "_mis"}, misaligned, 1);
    check({tag, "_afault"}, access_fault, 0);
    check({tag, "_data0"}, load_data, 0);
    check({tag, "_noreq"}, bus_req, 0);
    check({tag, "_stall"}, stall, 0);
    tick();
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_noreq2"}, bus_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state.
    tick();
    tick();
    check("rst_done", done, 0);
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wstrb", bus_wstrb, 0);
    check("rst_data", load_data, 0);
    check("rst_stall", stall, 0);
    reset_n = 1'b1;
    tick();

    // Loads.
    run_load("lw", F3_W, 32'h100, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("lb", F3_B, 32'h103, 32'h100, 32'h80FF_FF7F, 32'hFFFF_FF80);
    run_load("lbu", F3_BU, 32'h103, 32'h100, 32'h80FF_FF7F, 32'h0000_0080);
    run_load("lb0", F3_B, 32'h100, 32'h100, 32'h80FF_FF7F, 32'h0000_007F);
    run_load("lh", F3_H, 32'h102, 32'h100, 32'h80FF_FF7F, 32'hFFFF_80FF);
    run_load("lhu", F3_HU, 32'h102, 32'h100, 32'h80FF_FF7F, 32'h0000_80FF);

    // Stores.
    run_store("sb", F3_B, 32'h201, 32'h0000_00AB, 32'h200, 32'hABAB_ABAB, 4'b0010);
    run_store("sh", F3_H, 32'h202, 32'h0000_1234, 32'h200, 32'h1234_1234, 4'b1100);
    run_store("sw", F3_W, 32'h204, 32'h1122_3344, 32'h204, 32'h1122_3344, 4'b1111);

    // Rejected accesses.
    run_bad("lw_mis", 1'b1, 1'b0, F3_W, 32'h102);
    run_bad("f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_bad("sh_mis", 1'b0, 1'b1, F3_H, 32'h201);
    run_bad("st_f3bu", 1'b0, 1'b1, F3_BU, 32'h200);
    run_bad("rd_wr", 1'b1, 1'b1, F3_W, 32'h100);

    // Timeout: bus_ready never arrives.
    issue(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
    tick();
    idle_in();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req) break;
      n++;
      tick();
    end
    check("to_req_cycles", n, TO);
    check("to_done", done, 1);
    check("to_afault", access_fault, 1);
    check("to_mis", misaligned, 0);
    check("to_data0", load_data, 0);
    check("to_addr_held", bus_addr, 32'h300);
    tick();
    check("to_done_clr", done, 0);

    // Ready on the last allowed BUSY cycle wins over the timeout.
    issue(1'b1, 1'b0, F3_W, 32'h304, 32'h0);
    tick();
    idle_in();
    repeat (TO - 1) tick();
    check("to16_req", bus_req, 1);
    bus_ready = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    bus_ready = 1'b0;
    check("to16_done", done, 1);
    check("to16_afault", access_fault, 0);
    check("to16_data", load_data, 32'h1234_5678);
    tick();

    // Asynchronous reset during BUSY.
    issue(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
    tick();
    idle_in();
    check("rb_req", bus_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rb_req0", bus_req, 0);
    check("rb_stall0", stall, 0);
    check("rb_done0", done, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rb_idle_done", done, 0);
    check("rb_idle_req", bus_req, 0);
    run_load("lw_post_rst", F3_W, 32'h104, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
